// File: rtl/f_d_queue_if.sv
// f_d_queue_if: fetch-to-decode packet type and the valid/ready handshake carrying it.
package f_d_pkg;
    typedef struct packed {
        logic [1:0]       mask;
        logic [1:0][31:0] pc;
    } preict_info_t;

    typedef struct packed {
        logic [1:0][31:0] insts;
        preict_info_t     preict_info;
    } f_d_pkg_t;
endpackage

interface handshake_if;
    import f_d_pkg::*;
    logic     valid;
    logic     ready;
    f_d_pkg_t data;
    modport sender(output valid, output data, input ready);
    modport receiver(input valid, input data, output ready);
endinterface

// File: rtl/f_d_queue.sv
// f_d_queue: circular buffer of fetch packets between fetch and decode, flushable on redirect.
module f_d_queue #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush_i,
    handshake_if.receiver          receiver,
    handshake_if.sender            sender,
    output logic [$clog2(DEPTH):0] count_o
);
    import f_d_pkg::*;
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    f_d_pkg_t      mem_q [DEPTH];
    logic          full, empty, push, pop;

    assign full           = count_q == (AW+1)'(DEPTH);
    assign empty          = count_q == '0;
    assign receiver.ready = !full && !flush_i;
    assign sender.valid   = !empty && !flush_i;
    // mask==0 packets are handshaken but never stored
    assign push           = receiver.valid && receiver.ready && |receiver.data.preict_info.mask;
    assign pop            = sender.valid && sender.ready;
    assign sender.data    = mem_q[head_q];
    assign count_o        = count_q;

    always_comb begin
        head_d  = flush_i ? '0 : pop  ? head_q + AW'(1) : head_q;
        tail_d  = flush_i ? '0 : push ? tail_q + AW'(1) : tail_q;
        count_d = flush_i ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= receiver.data;
    end
endmodule

// File: doc/f_d_queue.md
F_D_QUEUE -- requirements
Module: f_d_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered fetch packets; legal values are powers of two, 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  front-end redirect; discards all buffered packets.
REQ-005 receiver  handshake_if.receiver  f_d_pkg_t  packets from fetch: data.insts[1:0][31:0], data.preict_info.mask[1:0], data.preict_info.pc[1:0][31:0], plus valid and ready.
REQ-006 sender  handshake_if.sender  f_d_pkg_t  packets to decode; same payload layout as receiver.
REQ-007 count_o  output  $clog2(DEPTH)+1  number of packets currently held.

Function
REQ-008 Storage SHALL be a circular buffer of DEPTH whole f_d_pkg_t entries with head and tail pointers of $clog2(DEPTH) bits and a count register of $clog2(DEPTH)+1 bits.
REQ-009 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-010 Full is defined as count==DEPTH; empty is defined as count==0.
REQ-011 receiver.ready SHALL equal !full & !flush_i, driven from registered state only.
REQ-012 There SHALL be no bypass of a pop freeing a slot in the same cycle when full.
REQ-013 A push SHALL occur when receiver.valid & receiver.ready & (preict_info.mask != 2'b00).
REQ-014 A handshaken packet with mask==2'b00 SHALL be accepted and dropped: not stored, no pointer or count change.
REQ-015 A push SHALL write the entry at tail, unmodified, then advance tail.
REQ-016 sender.valid SHALL equal !empty & !flush_i.
REQ-017 sender.data SHALL present the entry at head, unmodified.
REQ-018 While sender.valid=1 and sender.ready=0, sender.data SHALL hold stable.
REQ-019 A pop SHALL occur when sender.valid & sender.ready, and SHALL advance head.
REQ-020 Latency: a packet pushed in cycle t SHALL first be visible with sender.valid=1 in cycle t+1; there is no same-cycle pass-through.
REQ-021 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-022 Packets SHALL leave in strict push order; none duplicated, none lost except by flush or the mask==0 drop.
REQ-023 When flush_i=1 in cycle t, head, tail and count SHALL be 0 at t+1.
REQ-024 When flush_i=1, any concurrent push or pop SHALL be suppressed.
REQ-025 Entry payload storage SHALL NOT need clearing on flush.
REQ-026 count_o SHALL be the registered count.
REQ-027 receiver.ready and sender.valid SHALL NOT depend combinationally on receiver.valid or sender.ready.

Reset
REQ-028 When rst_n=0, head, tail and count SHALL asynchronously become 0.
REQ-029 During and after reset: sender.valid=0, receiver.ready=1 (when flush_i=0), count_o=0.
REQ-030 Entry payload registers SHALL NOT require reset.
REQ-031 Reset asserted mid-operation SHALL discard all contents, with the same effect as flush.
REQ-032 The first push after rst_n deasserts SHALL be accepted on the first rising edge with rst_n=1.

Verification
REQ-033 The bench SHALL cover fill to full: DEPTH=4, sender.ready=0, push pc0=0x1C000000, 0x1C000008, 0x1C000010, 0x1C000018, mask=2'b11 -> count_o=4 and receiver.ready=0 the cycle after the 4th push; sender.data.pc[0]=0x1C000000 throughout.
REQ-034 The bench SHALL cover drain order: from full, hold sender.ready=1 -> pc[0] sequence 0x1C000000, 0x1C000008, 0x1C000010, 0x1C000018 on 4 consecutive cycles, then sender.valid=0 and count_o=0.
REQ-035 The bench SHALL cover simultaneous push/pop at count=2: count_o stays 2 and order is preserved across pointer wrap (10 packets streamed continuously with both valid and ready held at 1).
REQ-036 The bench SHALL cover the empty-mask drop: push mask=2'b00 -> receiver.ready=1 during the handshake, count_o unchanged, the packet never appears on sender.
REQ-037 The bench SHALL cover flush with simultaneous push and pop: count=3, flush_i=1 for one cycle -> next cycle count_o=0 and sender.valid=0; the next push of pc0=0x1C000100 is output first.
REQ-038 The bench SHALL cover reset mid-stream: rst_n=0 asserted asynchronously between edges at count=2 -> sender.valid=0 immediately and count_o=0; after release, the first push is visible at t+1.
